// File: rtl/multi_debouncer.sv
// multi_debouncer: per-channel synchroniser, stability-counter debouncer,
// press/release pulse generator and long-press detector. Channels are fully
// independent; every output comes straight from a flop.
module multi_debouncer #(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 500000,
    parameter int                  HOLD_CYCLES     = 50000000,
    parameter logic [CHANNELS-1:0] INVERT          = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] held,
    output logic [CHANNELS-1:0] chk
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    // Keep the hold counter at least one bit wide so HOLD_CYCLES==0 still elaborates.
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [DW-1:0] STAB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] STAB_ONE  = DW'(1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic          HOLD_EN   = (HOLD_CYCLES > 0) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] sync_r     [CHANNELS];
    logic [DW-1:0]          stab_cnt_r [CHANNELS];
    logic [DW-1:0]          stab_cnt_s [CHANNELS];
    logic [HW-1:0]          hold_cnt_r [CHANNELS];
    logic [HW-1:0]          hold_cnt_s [CHANNELS];

    logic [CHANNELS-1:0] level_s;
    logic [CHANNELS-1:0] out_r,  out_s;
    logic [CHANNELS-1:0] rise_r, rise_s;
    logic [CHANNELS-1:0] fall_r, fall_s;
    logic [CHANNELS-1:0] held_r, held_s;
    logic [CHANNELS-1:0] chk_r,  chk_s;

    // Synchronised level, flipped for active-low pins so 1 always means "pressed".
    always_comb begin
        level_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            level_s[i] = sync_r[i][SYNC_STAGES-1] ^ INVERT[i];
        end
    end

    // Stability counter: accept a new level only after DEBOUNCE_CYCLES disagreeing cycles in a row.
    always_comb begin
        stab_cnt_s = stab_cnt_r;
        out_s      = out_r;
        rise_s     = {CHANNELS{1'b0}};
        fall_s     = {CHANNELS{1'b0}};
        chk_s      = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (level_s[i] == out_r[i]) begin
                // Any agreeing cycle aborts a pending change.
                stab_cnt_s[i] = {DW{1'b0}};
                chk_s[i]      = 1'b0;
            end else if (stab_cnt_r[i] == STAB_LAST) begin
                // Terminal count: take the new level and flag the edge in the same cycle.
                out_s[i]      = level_s[i];
                stab_cnt_s[i] = {DW{1'b0}};
                chk_s[i]      = 1'b0;
                rise_s[i]     = level_s[i];
                fall_s[i]     = ~level_s[i];
            end else begin
                stab_cnt_s[i] = stab_cnt_r[i] + STAB_ONE;
                chk_s[i]      = 1'b1;
            end
        end
    end

    // Hold counter: counts cycles the accepted level has been 1, saturating; cleared as out drops.
    always_comb begin
        hold_cnt_s = hold_cnt_r;
        held_s     = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (out_r[i] && out_s[i]) begin
                if (hold_cnt_r[i] == HOLD_MAX) begin
                    hold_cnt_s[i] = hold_cnt_r[i];
                end else begin
                    hold_cnt_s[i] = hold_cnt_r[i] + HOLD_ONE;
                end
            end else begin
                hold_cnt_s[i] = {HW{1'b0}};
            end
            // Uses the next out value so held falls on the very edge out falls.
            held_s[i] = HOLD_EN & out_s[i] & (hold_cnt_s[i] == HOLD_MAX);
        end
    end

    // State registers; sync flops reset to the idle pin level so reset release is silent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_r[i]     <= {SYNC_STAGES{INVERT[i]}};
                stab_cnt_r[i] <= {DW{1'b0}};
                hold_cnt_r[i] <= {HW{1'b0}};
            end
            out_r  <= {CHANNELS{1'b0}};
            rise_r <= {CHANNELS{1'b0}};
            fall_r <= {CHANNELS{1'b0}};
            held_r <= {CHANNELS{1'b0}};
            chk_r  <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_r[i]     <= {sync_r[i][SYNC_STAGES-2:0], in[i]};
                stab_cnt_r[i] <= stab_cnt_s[i];
                hold_cnt_r[i] <= hold_cnt_s[i];
            end
            out_r  <= out_s;
            rise_r <= rise_s;
            fall_r <= fall_s;
            held_r <= held_s;
            chk_r  <= chk_s;
        end
    end

    assign out  = out_r;
    assign rise = rise_r;
    assign fall = fall_r;
    assign held = held_r;
    assign chk  = chk_r;

endmodule
